operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Issue stage between decode and execute. Accepts a decoded instruction (rs1/rs2/rd + opaque ctx),
//  drives the register-file read port, and forwards the writeback bus to the register-file write port.
//  Bypasses writes the 1-cycle sync read would miss, and keeps held operands coherent while stalled.
//  Produces operands on a valid/ready interface toward execute.
// PARAMETERS
//  W      32  data width of registers and operands
//  CTX_W  32  width of the opaque per-instruction context passed through unchanged
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      decoded instruction present
//  in_ready     out  1      stage accepts instruction this cycle
//  in_rs1       in   5      source register 1 index
//  in_rs2       in   5      source register 2 index
//  in_rd        in   5      destination index (passed through)
//  in_ctx       in   CTX_W  opaque context (passed through)
//  rf_ren       out  1      regfile read enable
//  rf_rs1       out  5      regfile read address 1
//  rf_rs2       out  5      regfile read address 2
//  rf_rs1_val   in   W      regfile read data 1, valid cycle after rf_ren
//  rf_rs2_val   in   W      regfile read data 2, valid cycle after rf_ren
//  wb_valid     in   1      writeback request
//  wb_rd        in   5      writeback register index
//  wb_val       in   W      writeback data
//  rf_wen       out  1      regfile write enable
//  rf_rd        out  5      regfile write address
//  rf_rd_val    out  W      regfile write data
//  out_valid    out  1      operands valid toward execute
//  out_ready    in   1      execute consumes operands
//  out_rs1_val  out  W      operand 1
//  out_rs2_val  out  W      operand 2
//  out_rd       out  5      destination index
//  out_ctx      out  CTX_W  context
// BEHAVIOUR
//  - States: IDLE, READ, OUT. Reset -> IDLE; all output regs 0, out_valid 0. Async reset mid-operation
//    drops any in-flight instruction.
//  - in_ready = (IDLE) | (OUT & out_ready); accept = in_valid & in_ready.
//  - rf_ren = accept; rf_rs1/rf_rs2 = in_rs1/in_rs2 (combinational). Latch rs1, rs2, rd, ctx on accept.
//  - Write path (combinational): rf_wen = wb_valid & (wb_rd != 0), rf_rd = wb_rd, rf_rd_val = wb_val.
//  - Regfile read returns the pre-write value when a write hits the same index in the read cycle.
//    Therefore, in the accept cycle, if rf_wen & wb_rd == in_rsN, latch byp_N = 1 and byp_val_N = wb_val.
//  - READ (always 1 cycle) selects opN, priority high to low:
//    1. rsN == 0 -> 0.
//    2. rf_wen & wb_rd == rsN -> wb_val.
//    3. byp_N -> byp_val_N.
//    4. else rf_rsN_val.
//    Register opN into out_rsN_val, set out_valid, go to OUT.
//  - OUT:
//    - If rf_wen & wb_rd == out index N and N != 0, update out_rsN_val <= wb_val.
//      Applies while stalled and also in the handshake cycle.
//    - out_ready & in_valid -> READ (new accept).
//    - out_ready & !in_valid -> IDLE, out_valid 0.
//    - !out_ready -> hold all outputs stable.
//  - Latency: accept in cycle N -> out_valid in cycle N+2. Throughput: 1 instruction per 2 cycles.
//  - rs1 == rs2 is legal; both operands get identical values.
//  - Writeback to x0 is never forwarded to the regfile and never bypassed.
// TESTING
//  1. Preload x5=0x11, x6=0x22; accept rs1=5, rs2=6 at cycle N.
//     -> rf_ren=1 at N; out_valid at N+2 with 0x11/0x22; out_rd and out_ctx unchanged.
//  2. Same-cycle bypass: wb x5=0xAA in the accept cycle of rs1=5 -> out_rs1_val=0xAA (not the stale 0x11).
//  3. READ-cycle bypass: wb x6=0xBB one cycle after accept of rs2=6 -> out_rs2_val=0xBB.
//  4. Stall coherence: hold out_ready=0 for 3 cycles and write x5=0xCC during the stall
//     -> out_rs1_val becomes 0xCC next cycle; out_rd/out_ctx stay stable.
//  5. x0: rs1=0 with wb x0=0xFF -> out_rs1_val=0, rf_wen=0.
//  6. Back-to-back with out_ready=1 -> accepts at N, N+2, N+4; deassert rst_n mid-READ
//     -> out_valid=0 immediately, IDLE after release.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage.
// Takes a decoded instruction, reads its two source registers from a
// synchronous-read register file, and hands the operands to execute over a
// valid/ready handshake. The writeback bus is passed to the register-file
// write port. Writes that the one-cycle read would miss are bypassed, and
// operands held during a stall follow later writes to the same register.
module operand_fetch #(
    parameter int W     = 32,
    parameter int CTX_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [CTX_W-1:0] in_ctx,
    output logic             rf_ren,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    input  logic [W-1:0]     rf_rs1_val,
    input  logic [W-1:0]     rf_rs2_val,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [W-1:0]     wb_val,
    output logic             rf_wen,
    output logic [4:0]       rf_rd,
    output logic [W-1:0]     rf_rd_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_rs1_val,
    output logic [W-1:0]     out_rs2_val,
    output logic [4:0]       out_rd,
    output logic [CTX_W-1:0] out_ctx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state_r;
    logic [4:0]       rs1_r;
    logic [4:0]       rs2_r;
    logic [4:0]       rd_r;
    logic [CTX_W-1:0] ctx_r;
    logic             byp1_r;
    logic             byp2_r;
    logic [W-1:0]     byp_val1_r;
    logic [W-1:0]     byp_val2_r;

    logic             accept_s;
    logic [W-1:0]     op1_s;
    logic [W-1:0]     op2_s;

    // Operand source selection: x0 reads as zero, then a write landing in
    // this cycle, then a write captured in the accept cycle (which the
    // register file returned as the old value), then the register file.
    function automatic logic [W-1:0] sel_operand(
        input logic [4:0]   idx,
        input logic         wen,
        input logic [4:0]   wrd,
        input logic [W-1:0] wval,
        input logic         byp,
        input logic [W-1:0] byp_val,
        input logic [W-1:0] rf_val
    );
        logic [W-1:0] res;
        if (idx == 5'd0) begin
            res = {W{1'b0}};
        end else if (wen && (wrd == idx)) begin
            res = wval;
        end else if (byp) begin
            res = byp_val;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    // Handshake, register-file read/write ports (write to x0 is suppressed).
    always_comb begin
        in_ready  = (state_r == IDLE) || ((state_r == OUT) && out_ready);
        accept_s  = in_valid && in_ready;
        rf_ren    = accept_s;
        rf_rs1    = in_rs1;
        rf_rs2    = in_rs2;
        rf_wen    = wb_valid && (wb_rd != 5'd0);
        rf_rd     = wb_rd;
        rf_rd_val = wb_val;
    end

    // Operand values as they would be registered at the end of READ.
    always_comb begin
        op1_s = sel_operand(rs1_r, rf_wen, wb_rd, wb_val, byp1_r, byp_val1_r, rf_rs1_val);
        op2_s = sel_operand(rs2_r, rf_wen, wb_rd, wb_val, byp2_r, byp_val2_r, rf_rs2_val);
    end

    // Instruction latch and accept-cycle bypass capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_r      <= 5'd0;
            rs2_r      <= 5'd0;
            rd_r       <= 5'd0;
            ctx_r      <= {CTX_W{1'b0}};
            byp1_r     <= 1'b0;
            byp2_r     <= 1'b0;
            byp_val1_r <= {W{1'b0}};
            byp_val2_r <= {W{1'b0}};
        end else if (accept_s) begin
            rs1_r      <= in_rs1;
            rs2_r      <= in_rs2;
            rd_r       <= in_rd;
            ctx_r      <= in_ctx;
            byp1_r     <= rf_wen && (wb_rd == in_rs1);
            byp2_r     <= rf_wen && (wb_rd == in_rs2);
            byp_val1_r <= wb_val;
            byp_val2_r <= wb_val;
        end
    end

    // Stage FSM with registered outputs toward execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            out_valid   <= 1'b0;
            out_rs1_val <= {W{1'b0}};
            out_rs2_val <= {W{1'b0}};
            out_rd      <= 5'd0;
            out_ctx     <= {CTX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (accept_s) begin
                        state_r <= READ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    out_rs1_val <= op1_s;
                    out_rs2_val <= op2_s;
                    out_rd      <= rd_r;
                    out_ctx     <= ctx_r;
                    out_valid   <= 1'b1;
                    state_r     <= OUT;
                end
                OUT: begin
                    // Held operands track writes to their source registers,
                    // including in the handshake cycle.
                    if (rf_wen && (wb_rd == rs1_r) && (rs1_r != 5'd0)) begin
                        out_rs1_val <= wb_val;
                    end
                    if (rf_wen && (wb_rd == rs2_r) && (rs2_r != 5'd0)) begin
                        out_rs2_val <= wb_val;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            state_r <= READ;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a synchronous-read register file model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_ctx;
    logic        rf_ren;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rs1_val, rf_rs2_val;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_val;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic [31:0] out_ctx;

    int n_cmp = 0;
    int n_err = 0;

    operand_fetch #(.W(32), .CTX_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_ctx(in_ctx),
        .rf_ren(rf_ren), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_val(wb_val),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_rd_val(rf_rd_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_ctx(out_ctx)
    );

    always #5 clk = ~clk;

    // Register file: read data appears the cycle after rf_ren and returns
    // the pre-write value on a same-cycle write to the same index.
    logic [31:0] regs [32];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) regs[k] <= 32'd0;
            rf_rs1_val <= 32'd0;
            rf_rs2_val <= 32'd0;
        end else begin
            if (rf_ren) begin
                rf_rs1_val <= regs[rf_rs1];
                rf_rs2_val <= regs[rf_rs2];
            end
            if (rf_wen) regs[rf_rd] <= rf_rd_val;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] val);
        wb_valid = en;
        wb_rd    = rd;
        wb_val   = val;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] ctx;
        logic        wb0_en;  logic [4:0] wb0_rd;  logic [31:0] wb0_val;  // accept cycle
        logic        wb1_en;  logic [4:0] wb1_rd;  logic [31:0] wb1_val;  // READ cycle
        logic        exp_wen;
        logic [31:0] exp1, exp2;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Preload x5=0x11, x6=0x22, x7=0x33. Expectations follow the writes in order.
        vecs[0] = '{5'd5, 5'd6, 5'd3, 32'hCAFE0001, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 32'h11, 32'h22};
        vecs[1] = '{5'd5, 5'd6, 5'd4, 32'hCAFE0002, 1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'h0,  1'b1, 32'hAA, 32'h22};
        vecs[2] = '{5'd5, 5'd6, 5'd8, 32'hCAFE0003, 1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'hBB, 1'b0, 32'hAA, 32'hBB};
        vecs[3] = '{5'd0, 5'd7, 5'd1, 32'hCAFE0004, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0,  32'h33};
        vecs[4] = '{5'd7, 5'd7, 5'd2, 32'hCAFE0005, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 32'h33, 32'h33};
        vecs[5] = '{5'd7, 5'd7, 5'd31, 32'hCAFE0006, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h44, 1'b0, 32'h44, 32'h44};
        vecs[6] = '{5'd6, 5'd5, 5'd10, 32'hCAFE0007, 1'b1, 5'd6, 32'h55, 1'b1, 5'd5, 32'h66, 1'b1, 32'h55, 32'h66};
        vecs[7] = '{5'd0, 5'd0, 5'd11, 32'hCAFE0008, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77, 1'b0, 32'h0,  32'h0};

        rst_n = 1'b0; in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
        in_ctx = 32'd0; out_ready = 1'b1;
        set_wb(1'b0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_rs1", {32'd0, out_rs1_val}, 64'd0);
        check("rst_out_rs2", {32'd0, out_rs2_val}, 64'd0);
        check("rst_out_rd", {59'd0, out_rd}, 64'd0);
        check("rst_out_ctx", {32'd0, out_ctx}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload via the write path
        set_wb(1'b1, 5'd5, 32'h11);
        #1;
        check("pre_rf_wen", {63'd0, rf_wen}, 64'd1);
        check("pre_rf_rd", {59'd0, rf_rd}, 64'd5);
        check("pre_rf_rd_val", {32'd0, rf_rd_val}, 64'h11);
        @(negedge clk); set_wb(1'b1, 5'd6, 32'h22);
        @(negedge clk); set_wb(1'b1, 5'd7, 32'h33);
        @(negedge clk); set_wb(1'b0, 5'd0, 32'h0);
        @(negedge clk);

        // Table-driven single instructions, out_ready high
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
            in_rd = vecs[i].rd; in_ctx = vecs[i].ctx;
            set_wb(vecs[i].wb0_en, vecs[i].wb0_rd, vecs[i].wb0_val);
            #1;
            check($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
            check($sformatf("v%0d_rf_ren", i), {63'd0, rf_ren}, 64'd1);
            check($sformatf("v%0d_rf_rs1", i), {59'd0, rf_rs1}, {59'd0, vecs[i].rs1});
            check($sformatf("v%0d_rf_rs2", i), {59'd0, rf_rs2}, {59'd0, vecs[i].rs2});
            check($sformatf("v%0d_rf_wen", i), {63'd0, rf_wen}, {63'd0, vecs[i].exp_wen});
            @(negedge clk);
            in_valid = 1'b0;
            set_wb(vecs[i].wb1_en, vecs[i].wb1_rd, vecs[i].wb1_val);
            #1;
            check($sformatf("v%0d_read_valid", i), {63'd0, out_valid}, 64'd0);
            check($sformatf("v%0d_read_ren", i), {63'd0, rf_ren}, 64'd0);
            @(negedge clk);
            set_wb(1'b0, 5'd0, 32'h0);
            #1;
            check($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("v%0d_rs1_val", i), {32'd0, out_rs1_val}, {32'd0, vecs[i].exp1});
            check($sformatf("v%0d_rs2_val", i), {32'd0, out_rs2_val}, {32'd0, vecs[i].exp2});
            check($sformatf("v%0d_out_rd", i), {59'd0, out_rd}, {59'd0, vecs[i].rd});
            check($sformatf("v%0d_out_ctx", i), {32'd0, out_ctx}, {32'd0, vecs[i].ctx});
            @(negedge clk);
            #1;
            check($sformatf("v%0d_idle_valid", i), {63'd0, out_valid}, 64'd0);
        end
        // Register file now: x5=0x66, x6=0x55, x7=0x44

        // Stall coherence
        out_ready = 1'b0;
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_rd = 5'd9; in_ctx = 32'h12345678;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("st_valid", {63'd0, out_valid}, 64'd1);
        check("st_in_ready", {63'd0, in_ready}, 64'd0);
        check("st_rs1_pre", {32'd0, out_rs1_val}, 64'h66);
        check("st_rs2_pre", {32'd0, out_rs2_val}, 64'h55);
        in_valid = 1'b1; in_rs1 = 5'd3; in_rd = 5'd4; in_ctx = 32'hDEADBEEF;
        set_wb(1'b1, 5'd5, 32'hCC);
        #1;
        check("st_no_accept", {63'd0, rf_ren}, 64'd0);
        @(negedge clk);
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        check("st_rs1_upd", {32'd0, out_rs1_val}, 64'hCC);
        check("st_rs2_hold", {32'd0, out_rs2_val}, 64'h55);
        check("st_rd_hold", {59'd0, out_rd}, 64'd9);
        check("st_ctx_hold", {32'd0, out_ctx}, 64'h12345678);
        @(negedge clk);
        check("st_valid3", {63'd0, out_valid}, 64'd1);
        check("st_rs1_3", {32'd0, out_rs1_val}, 64'hCC);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("st_release", {63'd0, out_valid}, 64'd0);

        // Back-to-back: accepts every other cycle, out_valid at N+2
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_rd = 5'd12; in_ctx = 32'hB2B;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("b2b_ren_c%0d", c), {63'd0, rf_ren}, {63'd0, (c % 2) == 0});
            check($sformatf("b2b_valid_c%0d", c), {63'd0, out_valid}, {63'd0, (c >= 2) && ((c % 2) == 0)});
            if ((c >= 2) && ((c % 2) == 0))
                check($sformatf("b2b_rs1_c%0d", c), {32'd0, out_rs1_val}, 64'hCC);
            @(negedge clk);
        end
        // Now in READ: async reset drops the instruction
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_valid_%0d", c), {63'd0, out_valid}, 64'd0);
        end
        in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd13;
        #1;
        check("post_rst_accept", {63'd0, rf_ren}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out", {63'd0, out_valid}, 64'd1);
        check("post_rst_rd", {59'd0, out_rd}, 64'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
